pc_seq: RTL

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pc_seq.sv
// ============================================================================
// Module   : pc_seq
// Purpose  : PC-source sequencer that arbitrates the next-PC select between
//            the main control FSM, hardware interrupt entry and ERET return.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq (
    input  logic       clk_I,
    input  logic       rst_n_I,
    input  logic [2:0] pcsrc_req_I,
    input  logic       pcwr_req_I,
    input  logic       instr_end_I,
    input  logic       eret_I,
    input  logic [5:0] int_req_I,
    input  logic [5:0] IM_I,
    input  logic       IE_I,
    output logic [2:0] PCSrc_O,
    output logic       PCWr_O,
    output logic       EPCWr_O,
    output logic       EXL_O,
    output logic       hold_O,
    output logic [5:0] int_pend_O
);

    // Next-PC mux select encoding shared with the datapath.
    localparam logic [2:0] MUX_PCSrc_PCCYCLE = 3'd0;
    localparam logic [2:0] MUX_PCSrc_BRANCH  = 3'd1;
    localparam logic [2:0] MUX_PCSrc_JUMPADD = 3'd2;
    localparam logic [2:0] MUX_PCSrc_JUMPREG = 3'd3;
    localparam logic [2:0] MUX_PCSrc_EPC     = 3'd4;
    localparam logic [2:0] MUX_PCSrc_ISR     = 3'd5;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        INT_SAVE  = 2'd1,
        INT_JUMP  = 2'd2,
        ERET_JUMP = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       exl_q, exl_d;
    logic [5:0] int_pend_q;

    logic       w_int_taken;
    logic       w_eret_taken;

    assign w_eret_taken = (state_q == RUN) && eret_I && exl_q;
    assign w_int_taken  = (state_q == RUN) && instr_end_I && IE_I && !exl_q
                          && (|int_pend_q);

    // ERET has priority; a masked interrupt is re-evaluated once EXL clears.
    always_comb begin
        state_d = state_q;
        exl_d   = exl_q;
        case (state_q)
            RUN: begin
                if (w_eret_taken) begin
                    state_d = ERET_JUMP;
                end else if (w_int_taken) begin
                    state_d = INT_SAVE;
                end
            end
            INT_SAVE: begin
                state_d = INT_JUMP;
                exl_d   = 1'b1;
            end
            INT_JUMP: begin
                state_d = RUN;
            end
            ERET_JUMP: begin
                state_d = RUN;
                exl_d   = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_I or negedge rst_n_I) begin
        if (!rst_n_I) begin
            state_q    <= RUN;
            exl_q      <= 1'b0;
            int_pend_q <= 6'h00;
        end else begin
            state_q    <= state_d;
            exl_q      <= exl_d;
            int_pend_q <= int_req_I & IM_I;
        end
    end

    // Outside RUN the outputs depend on state alone; reset forces a safe idle.
    always_comb begin
        PCSrc_O = MUX_PCSrc_PCCYCLE;
        PCWr_O  = 1'b0;
        EPCWr_O = 1'b0;
        hold_O  = 1'b0;
        if (rst_n_I) begin
            case (state_q)
                RUN: begin
                    PCSrc_O = pcsrc_req_I;
                    PCWr_O  = pcwr_req_I;
                end
                INT_SAVE: begin
                    EPCWr_O = 1'b1;
                    hold_O  = 1'b1;
                end
                INT_JUMP: begin
                    PCSrc_O = MUX_PCSrc_ISR;
                    PCWr_O  = 1'b1;
                    hold_O  = 1'b1;
                end
                ERET_JUMP: begin
                    PCSrc_O = MUX_PCSrc_EPC;
                    PCWr_O  = 1'b1;
                    hold_O  = 1'b1;
                end
                default: begin
                    PCSrc_O = MUX_PCSrc_PCCYCLE;
                end
            endcase
        end
    end

    assign EXL_O      = exl_q;
    assign int_pend_O = int_pend_q;

    // Encodings driven by the main FSM only; listed to document the full map.
    logic w_unused;
    assign w_unused = ^{MUX_PCSrc_BRANCH, MUX_PCSrc_JUMPADD, MUX_PCSrc_JUMPREG};

endmodule

`default_nettype wire
